// File: rtl/video_timing_ovl_gen.sv
// Programmable HS/VS/DE timing generator with frame-read request,
// 1-cycle-latency pixel fetch and a frame-latched rectangle overlay.
module video_timing_ovl_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CW         = 12
) (
  input  logic                  video_clk,
  input  logic                  rst,
  output logic                  read_req,
  input  logic                  read_req_ack,
  output logic                  read_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  ovl_en,
  input  logic                  ovl_mode,
  input  logic [CW-1:0]         ovl_x0,
  input  logic [CW-1:0]         ovl_x1,
  input  logic [CW-1:0]         ovl_y0,
  input  logic [CW-1:0]         ovl_y1,
  input  logic [DATA_WIDTH-1:0] ovl_color,
  output logic                  hs,
  output logic                  vs,
  output logic                  de,
  output logic                  frame_start,
  output logic [DATA_WIDTH-1:0] vout_data
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  typedef struct packed {
    logic          en;
    logic          mode;
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y0;
    logic [CW-1:0] y1;
  } ovl_t;

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  ovl_t          ovl_q, ovl_d;
  logic          de1_q, hs1_q, vs1_q, fs1_q;
  logic [CW-1:0] px_q, py_q;
  logic          de_q, hs_q, vs_q, fs_q, req_q;
  logic          hs_d, vs_d, req_d;
  logic [DATA_WIDTH-1:0] vout_q, vout_d;

  logic de0, hs0, vs0, fs0, frame_end, req_set;
  logic in_box, on_edge, hit;

  assign de0 = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs0 = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign vs0 = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
  assign fs0 = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign req_set   = (h_cnt_q == '0) && (v_cnt_q == VS_BEG);

  // An inverted box (x0>x1 or y0>y1) fails the range test on its own.
  assign in_box  = (px_q >= ovl_q.x0) && (px_q <= ovl_q.x1) &&
                   (py_q >= ovl_q.y0) && (py_q <= ovl_q.y1);
  assign on_edge = (px_q == ovl_q.x0) || (px_q == ovl_q.x1) ||
                   (py_q == ovl_q.y0) || (py_q == ovl_q.y1);
  assign hit     = ovl_q.en && in_box && (!ovl_q.mode || on_edge);

  always_comb begin
    h_cnt_d = h_cnt_q + CW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
    end
    ovl_d = ovl_q;
    if (frame_end) begin
      ovl_d = '{ovl_en, ovl_mode, ovl_x0, ovl_x1, ovl_y0, ovl_y1};
    end
    hs_d = hs1_q ? HS_POL : ~HS_POL;
    vs_d = vs1_q ? VS_POL : ~VS_POL;
    vout_d = '0;
    if (de1_q) begin
      vout_d = hit ? ovl_color : read_data;
    end
    req_d = req_q;
    if (req_set) begin
      req_d = 1'b1;
    end else if (read_req_ack) begin
      req_d = 1'b0;
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      ovl_q   <= '0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      fs1_q   <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      vout_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      ovl_q   <= ovl_d;
      de1_q   <= de0;
      hs1_q   <= hs0;
      vs1_q   <= vs0;
      fs1_q   <= fs0;
      px_q    <= h_cnt_q;
      py_q    <= v_cnt_q;
      de_q    <= de1_q;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs1_q;
      vout_q  <= vout_d;
      req_q   <= req_d;
    end
  end

  assign read_en     = de0;
  assign read_req    = req_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign vout_data   = vout_q;

endmodule

// File: tb/tb_video_timing_ovl_gen.sv
// Randomised self-checking bench for video_timing_ovl_gen against a
// position-based behavioural model on a 14x7 timing.
module tb_video_timing_ovl_gen;
  localparam int DW = 16;
  localparam int CW = 12;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  localparam logic [DW-1:0] COLOR = 16'h001F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic read_req, read_en;
  logic read_req_ack = 1'b0;
  logic [DW-1:0] read_data = '0;
  logic ovl_en = 1'b0, ovl_mode = 1'b0;
  logic [CW-1:0] ovl_x0 = '0, ovl_x1 = '0, ovl_y0 = '0, ovl_y1 = '0;
  logic [DW-1:0] ovl_color = COLOR;
  logic hs, vs, de, frame_start;
  logic [DW-1:0] vout_data;

  video_timing_ovl_gen #(
    .DATA_WIDTH(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .video_clk(clk), .rst(rst),
    .read_req(read_req), .read_req_ack(read_req_ack),
    .read_en(read_en), .read_data(read_data),
    .ovl_en(ovl_en), .ovl_mode(ovl_mode),
    .ovl_x0(ovl_x0), .ovl_x1(ovl_x1),
    .ovl_y0(ovl_y0), .ovl_y1(ovl_y1),
    .ovl_color(ovl_color),
    .hs(hs), .vs(vs), .de(de),
    .frame_start(frame_start), .vout_data(vout_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit mode;
    int x0, x1, y0, y1;
  } cfg_t;

  cfg_t cfg [0:63];
  int checks = 0;
  int errors = 0;
  int t = 0;
  int ph = 0;
  int rq = 50;
  bit req_m = 1'b0;
  int n_de, n_vs, n_hs, n_col;

  function automatic bit active(int p);
    return (p % HT) < 8 && ((p / HT) % VT) < 4;
  endfunction

  function automatic logic [DW-1:0] pix(int p);
    return 16'(32'h1000 + ((p / HT) % VT) * 8 + p % HT);
  endfunction

  function automatic bit hit(int p);
    cfg_t c;
    int x, y;
    bit edge_px;
    c = cfg[p / FT];
    x = p % HT;
    y = (p / HT) % VT;
    edge_px = (x == c.x0) || (x == c.x1) || (y == c.y0) || (y == c.y1);
    return c.en && x >= c.x0 && x <= c.x1 && y >= c.y0 && y <= c.y1 &&
           (!c.mode || edge_px);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ph=%0d t=%0d actual=%h expected=%h",
               nm, ph, t, act, exp);
    end
  endtask

  task automatic check_outputs();
    int p, h, v;
    bit e_de;
    logic [DW-1:0] e_v;
    p = t - 2;
    h = (p >= 0) ? p % HT : 0;
    v = (p >= 0) ? (p / HT) % VT : 0;
    e_de = (p >= 0) && active(p);
    e_v = e_de ? (hit(p) ? COLOR : pix(p)) : '0;
    chk("de", 32'(de), 32'(e_de));
    chk("hs", 32'(hs), (p >= 0 && h >= 10 && h < 12) ? 0 : 1);
    chk("vs", 32'(vs), (p >= 0 && v == 5) ? 0 : 1);
    chk("frame_start", 32'(frame_start), (p >= 0 && p % FT == 0) ? 1 : 0);
    chk("vout_data", 32'(vout_data), 32'(e_v));
    chk("read_req", 32'(read_req), 32'(req_m));
    chk("read_en", 32'(read_en), 32'(active(t)));
    if (ph == 0 && t == 2) begin
      chk("pin_fs0", 32'(frame_start), 1);
      chk("pin_pix0", 32'(vout_data), 32'h1000);
    end
    if (ph == 0 && t == 70) chk("pin_req_lo", 32'(read_req), 0);
    if (ph == 0 && t == 71) chk("pin_req_hi", 32'(read_req), 1);
    if (ph == 0 && t == 2 * FT + 71) chk("pin_req_hold", 32'(read_req), 1);
    if (ph == 0 && t == 3 * FT + 11) chk("pin_req_ack", 32'(read_req), 0);
    if (ph == 0 && t == 5 * FT + 71) chk("pin_req_setwin", 32'(read_req), 1);
    if (ph == 1 && t == 2) chk("pin_rst_fs", 32'(frame_start), 1);
    if (ph == 1 && t == 70) chk("pin_rst_noreq", 32'(read_req), 0);
    if (p >= 0) begin
      n_de  += int'(de);
      n_vs  += int'(!vs);
      n_hs  += int'(!hs);
      n_col += int'(de && vout_data == COLOR);
      if (p % FT == FT - 1) begin
        if (p / FT == 0) begin
          chk("cnt_de", n_de, 32);
          chk("cnt_vs", n_vs, 14);
          chk("cnt_hs", n_hs, 14);
          chk("cnt_col_off", n_col, 0);
        end
        if (ph == 0 && p / FT == 3) chk("cnt_col_fill", n_col, 6);
        if (ph == 0 && p / FT == 4) chk("cnt_col_border", n_col, 6);
        if (ph == 0 && p / FT == 5) chk("cnt_col_inv", n_col, 0);
        n_de = 0; n_vs = 0; n_hs = 0; n_col = 0;
      end
    end
  endtask

  task automatic drive();
    int f, q;
    f = t / FT;
    q = t % FT;
    read_data = active(t - 1) ? pix(t - 1) : DW'($urandom);
    read_req_ack = 1'b0;
    if (ph == 0) begin
      if (f == 3 && q == 10) read_req_ack = 1'b1;
      if (f == 5 && q == 70) read_req_ack = 1'b1;
      if (f >= 6 && f <= 8) read_req_ack = ($urandom % 6) == 0;
      if (f == 2 && q == 40) begin
        ovl_en = 1'b1; ovl_mode = 1'b0;
        ovl_x0 = 2; ovl_x1 = 4; ovl_y0 = 1; ovl_y1 = 2;
      end
      if (f == 3 && q == 40) ovl_mode = 1'b1;
      if (f == 4 && q == 40) begin
        ovl_x0 = 5; ovl_x1 = 3;
      end
      if (f >= 6 && q == 0) rq = 20 + int'($urandom % 60);
      if (f >= 6 && q == rq) begin
        ovl_en = ($urandom % 4) != 0;
        ovl_mode = 1'($urandom);
        ovl_x0 = CW'($urandom % 10); ovl_x1 = CW'($urandom % 10);
        ovl_y0 = CW'($urandom % 6);  ovl_y1 = CW'($urandom % 6);
      end
    end
    if (q == FT - 1)
      cfg[f + 1] = '{ovl_en, ovl_mode, int'(ovl_x0), int'(ovl_x1),
                     int'(ovl_y0), int'(ovl_y1)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if ((t - 1) % FT == 70) req_m = 1'b1;
    else if (read_req_ack) req_m = 1'b0;
    check_outputs();
    drive();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    t = 0; req_m = 1'b0;
    cfg[0] = '{0, 0, 0, 0, 0, 0};
    n_de = 0; n_vs = 0; n_hs = 0; n_col = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    release_reset();
    while (t < 10 * FT + 2 * HT + 5) step();
    #3 rst = 1'b1;
    #1;
    chk("rst_de", 32'(de), 0);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_vout", 32'(vout_data), 0);
    chk("rst_req", 32'(read_req), 0);
    @(posedge clk);
    ph = 1;
    read_req_ack = 1'b0;
    release_reset();
    while (t < 2 * FT + 10) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_ovl_gen.md
Name: video_timing_ovl_gen

Overview:
- Parametrised successor to the fixed-mode frame-read timing block.
- Generates programmable-resolution HS/VS/DE timing internally, with no external color_bar generator.
- Issues a per-frame read request to the frame-buffer reader and fetches pixels with a 1-cycle-latency read port.
- Outputs aligned video with a runtime-programmable rectangle overlay, in fill or 1-pixel-border mode.

Parameters:
- DATA_WIDTH, 16, pixel width.
- H_ACTIVE, 640, active pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, active lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- HS_POL, 0, hs active level (0 = active-low).
- VS_POL, 0, vs active level.
- CW, 12, coordinate/counter width; must satisfy 2^CW > H_TOTAL and 2^CW > V_TOTAL.

Ports:
- video_clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- read_req  out  1  start-of-frame read request; held until acknowledged.
- read_req_ack  in  1  reader acknowledge.
- read_en  out  1  pixel read enable (stage 0).
- read_data  in  DATA_WIDTH  pixel; valid 1 cycle after read_en.
- ovl_en  in  1  overlay enable.
- ovl_mode  in  1  0 = filled rectangle, 1 = 1-pixel border only.
- ovl_x0, ovl_x1  in  CW each  overlay column bounds, inclusive.
- ovl_y0, ovl_y1  in  CW each  overlay line bounds, inclusive.
- ovl_color  in  DATA_WIDTH  overlay pixel value.
- hs  out  1  horizontal sync.
- vs  out  1  vertical sync.
- de  out  1  data enable.
- frame_start  out  1  1-cycle pulse coincident with the first active pixel of a frame.
- vout_data  out  DATA_WIDTH  pixel out.

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
  - Active region comes first in both dimensions.
- Stage-0 signals, decoded combinationally from the counters:
  - de0 = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
  - hs0 active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs0 active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line.
- read_en = de0. Combinational; the only unregistered output.
- Pipeline: hs, vs and de are stage-0 values delayed exactly 2 clocks, applying polarity on output.
- vout_data is registered and aligned with de:
  - de=0: 0.
  - de=1 and pixel inside the overlay: ovl_color.
  - otherwise: read_data sampled at stage 1.
- Overlay hit, evaluated on the stage-1 pixel coordinates:
  - Requires latched enable = 1, x0 <= x <= x1, and y0 <= y <= y1.
  - Border mode additionally requires x==x0, x==x1, y==y0 or y==y1.
  - If x0>x1 or y0>y1, the overlay never hits.
  - Coordinates beyond the active area are simply never reached.
- Overlay latching: ovl_en, ovl_mode and the four bounds are latched into shadow registers when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1. Changes take effect at the next frame only; no mid-frame tearing.
- ovl_color is used live, without latching.
- read_req:
  - Sets on the clock following the first stage-0 cycle of vs0 (v_cnt==V_ACTIVE+V_FP, h_cnt==0).
  - Clears on read_req_ack.
  - Simultaneous set and ack: set wins.
  - A request still pending at the next set stays 1; no extra pulse.
- frame_start: registered pulse; high in the same cycle as de for pixel (0,0).
- Reset (asynchronous) clears:
  - h_cnt and v_cnt to 0.
  - Pipeline to inactive.
  - Overlay shadow to disabled.
  - Outputs: read_req=0, hs=~HS_POL, vs=~VS_POL, de=0, frame_start=0, vout_data=0.
- read_en follows counters, so it is 1 immediately after reset release, because (0,0) is active.
- Reset mid-line or mid-frame restarts timing at (0,0). A pending read_req is dropped.

Test Plan:
- Use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14), V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7), overlay disabled.
  - Timing check: de high 8 of every 14 clocks on lines 0-3.
  - hs low for 2 clocks starting 12 clocks after the line start (h_cnt=10, +2 latency).
  - vs low for exactly 14 clocks on line 5; frame period 98 clocks.
- Data alignment: reader returns read_data = 16'h1000 + pixel index one clock after each read_en.
  - vout_data must equal 16'h1000..16'h101F in order while de=1.
  - vout_data must be 0 while de=0.
  - frame_start is high only on pixel 0.
- Overlay fill: ovl_en=1, mode 0, x0=2, x1=4, y0=1, y1=2, color 16'h001F, written mid-frame.
  - Current frame: unaffected.
  - Next frame: lines 1-2, pixels 2-4 show 16'h001F (6 pixels); all other pixels show read_data.
- Overlay border: same box in mode 1.
  - Pixels (2..4,1), (2..4,2), and (2,y), (4,y) are colored.
  - Then set x0=5, x1=3: no overlay pixels appear.
- read_req handshake:
  - Ack held low: read_req rises 1 clock after line 5 starts and stays high across 2 frames.
  - Ack pulsed for 1 clock: read_req falls the next clock.
  - Ack asserted on the set cycle: read_req stays 1.
- Reset mid-frame at line 2, pixel 5:
  - All outputs go to reset values asynchronously.
  - After release, de rises 2 clocks later with frame_start=1, and no read_req occurs before line 5.
